// File: rtl/dqsw_delay_trainer.sv
// rtl/dqsw_delay_trainer.sv - DQSW delay-line training sequencer for one IOD lane
// Walks the delay tap upward until LATE rises after having been seen low, then backs off.
module dqsw_delay_trainer #(
    parameter int MAX_TAPS      = 128,
    parameter int TAP_W         = 7,
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_CYCLES = 8,
    parameter int BACKOFF_TAPS  = 4
) (
    input  logic             FAB_CLK,
    input  logic             RESET,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             FAIL,
    output logic [TAP_W-1:0] FINAL_TAP,
    output logic [TAP_W-1:0] EDGE_TAP,
    output logic [TAP_W-1:0] CUR_TAP,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             EYE_MONITOR_CLEAR_FLAGS,
    input  logic             EYE_MONITOR_EARLY,
    input  logic             EYE_MONITOR_LATE,
    input  logic             DELAY_LINE_OUT_OF_RANGE
);

    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_CLEAR, S_SAMPLE,
        S_EVAL, S_STEP, S_BACKOFF, S_DONE, S_FAIL
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [TAP_W-1:0]   cur_tap;
    logic [TAP_W-1:0]   edge_tap;
    logic [TAP_W-1:0]   final_tap;
    logic [TAP_W-1:0]   bk_left;
    logic [TAP_W-1:0]   bk_count;
    logic               bk_move;
    logic               prev_late;
    logic               first;
    logic               active;
    logic               edge_found;
    logic               at_last;
    logic               unused_early;

    assign unused_early = EYE_MONITOR_EARLY;
    assign active       = !(state == S_IDLE || state == S_DONE || state == S_FAIL);
    assign edge_found   = EYE_MONITOR_LATE && !first && !prev_late;
    assign at_last      = (cur_tap == TAP_W'(MAX_TAPS - 1));
    // Backoff is clamped here so the tap count can never wrap below zero.
    assign bk_count     = (int'(cur_tap) < BACKOFF_TAPS) ? cur_tap : TAP_W'(BACKOFF_TAPS);

    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_FAIL: if (START) state_next = S_LOAD;
            S_LOAD:   state_next = S_SETTLE;
            S_SETTLE: if (cnt == '0) state_next = S_CLEAR;
            S_CLEAR:  state_next = S_SAMPLE;
            S_SAMPLE: if (cnt == '0) state_next = S_EVAL;
            S_EVAL: begin
                if (edge_found) begin
                    state_next = (bk_count == '0) ? S_DONE : S_BACKOFF;
                end else if (at_last) begin
                    state_next = S_FAIL;
                end else begin
                    state_next = S_STEP;
                end
            end
            S_STEP:    state_next = S_SETTLE;
            S_BACKOFF: if (!bk_move && cnt == '0 && bk_left == '0) state_next = S_DONE;
            default:   state_next = S_IDLE;
        endcase
        if (active && DELAY_LINE_OUT_OF_RANGE) begin
            state_next = S_FAIL;
        end
    end

    always_comb begin
        DELAY_LINE_LOAD         = (state == S_LOAD);
        DELAY_LINE_MOVE         = (state == S_STEP) || (state == S_BACKOFF && bk_move);
        DELAY_LINE_DIRECTION    = (state == S_STEP);
        EYE_MONITOR_CLEAR_FLAGS = (state == S_CLEAR);
        BUSY                    = active;
        DONE                    = (state == S_DONE);
        FAIL                    = (state == S_FAIL);
    end

    assign CUR_TAP   = cur_tap;
    assign EDGE_TAP  = edge_tap;
    assign FINAL_TAP = final_tap;

    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            cnt       <= '0;
            cur_tap   <= '0;
            edge_tap  <= '0;
            final_tap <= '0;
            bk_left   <= '0;
            bk_move   <= 1'b0;
            prev_late <= 1'b0;
            first     <= 1'b1;
        end else begin
            if (state_next == S_SETTLE && state != S_SETTLE) begin
                cnt <= CNT_W'(SETTLE_CYCLES - 1);
            end else if (state_next == S_SAMPLE && state != S_SAMPLE) begin
                cnt <= CNT_W'(SAMPLE_CYCLES - 1);
            end else if (state == S_BACKOFF && bk_move) begin
                cnt <= CNT_W'(SETTLE_CYCLES - 1);
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (state_next == S_LOAD) begin
                        cur_tap   <= '0;
                        edge_tap  <= '0;
                        final_tap <= '0;
                        prev_late <= 1'b0;
                        first     <= 1'b1;
                    end
                end
                S_EVAL: begin
                    if (state_next == S_BACKOFF || state_next == S_DONE) begin
                        edge_tap <= cur_tap;
                        bk_left  <= bk_count;
                        bk_move  <= 1'b1;
                        if (state_next == S_DONE) final_tap <= cur_tap;
                    end else if (state_next == S_STEP) begin
                        prev_late <= EYE_MONITOR_LATE;
                        first     <= 1'b0;
                    end
                end
                S_STEP: cur_tap <= cur_tap + 1'b1;
                S_BACKOFF: begin
                    if (bk_move) begin
                        cur_tap <= cur_tap - 1'b1;
                        bk_left <= bk_left - 1'b1;
                        bk_move <= 1'b0;
                    end else if (cnt == '0 && bk_left != '0) begin
                        bk_move <= 1'b1;
                    end else if (state_next == S_DONE) begin
                        final_tap <= cur_tap;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dqsw_delay_trainer.sv
// tb/tb_dqsw_delay_trainer.sv - self-checking bench for dqsw_delay_trainer
// A timeline model expands each scenario into per-cycle expected outputs and stimulus.
module tb_dqsw_delay_trainer;

    localparam int MAXT    = 16;
    localparam int SETTLE  = 2;
    localparam int SAMPLE  = 4;
    localparam int BACKOFF = 2;

    logic       clk = 1'b0;
    logic       RESET, START, LATE, EARLY, OOR;
    logic       BUSY, DONE, FAIL, LOAD, MOVE, DIR, CLR;
    logic [3:0] FINAL_TAP, EDGE_TAP, CUR_TAP;

    int n_tests = 0;
    int n_fail  = 0;

    // {load, move, dir, clear, busy, done, fail, cur_tap, edge_tap, final_tap}
    logic [18:0] exp_q[$];
    bit          late_q[$];
    bit          oor_q[$];
    logic [3:0]  m_tap, m_edge, m_fin;

    always #5 clk = ~clk;

    dqsw_delay_trainer #(
        .MAX_TAPS(MAXT), .TAP_W(4), .SETTLE_CYCLES(SETTLE),
        .SAMPLE_CYCLES(SAMPLE), .BACKOFF_TAPS(BACKOFF)
    ) dut (
        .FAB_CLK(clk),
        .RESET(RESET),
        .START(START),
        .BUSY(BUSY),
        .DONE(DONE),
        .FAIL(FAIL),
        .FINAL_TAP(FINAL_TAP),
        .EDGE_TAP(EDGE_TAP),
        .CUR_TAP(CUR_TAP),
        .DELAY_LINE_LOAD(LOAD),
        .DELAY_LINE_MOVE(MOVE),
        .DELAY_LINE_DIRECTION(DIR),
        .EYE_MONITOR_CLEAR_FLAGS(CLR),
        .EYE_MONITOR_EARLY(EARLY),
        .EYE_MONITOR_LATE(LATE),
        .DELAY_LINE_OUT_OF_RANGE(OOR)
    );

    function automatic logic [18:0] actual();
        return {LOAD, MOVE, DIR, CLR, BUSY, DONE, FAIL, CUR_TAP, EDGE_TAP, FINAL_TAP};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic push(input bit ld, input bit mv, input bit dr, input bit cl,
                        input bit bz, input bit dn, input bit fl, input bit lt, input bit oo);
        exp_q.push_back({ld, mv, dr, cl, bz, dn, fl, m_tap, m_edge, m_fin});
        late_q.push_back(lt);
        oor_q.push_back(oo);
    endtask

    // late_map[t] is the LATE flag the IOD reports at tap t; oor_tap < 0 disables the fault.
    task automatic build(input logic [15:0] late_map, input int oor_tap);
        bit first = 1'b1;
        bit prev  = 1'b0;
        bit lt;
        bit ended = 1'b0;
        int n;
        exp_q.delete(); late_q.delete(); oor_q.delete();
        m_tap = 4'd0; m_edge = 4'd0; m_fin = 4'd0;
        push(1, 0, 0, 0, 1, 0, 0, late_map[0], 0);
        while (!ended) begin
            lt = late_map[m_tap];
            repeat (SETTLE) push(0, 0, 0, 0, 1, 0, 0, lt, 0);
            push(0, 0, 0, 1, 1, 0, 0, lt, 0);
            for (int i = 0; i < SAMPLE && !ended; i++) begin
                if (int'(m_tap) == oor_tap && i == 1) begin
                    push(0, 0, 0, 0, 1, 0, 0, lt, 1);
                    repeat (3) push(0, 0, 0, 0, 0, 0, 1, lt, 0);
                    ended = 1'b1;
                end else begin
                    push(0, 0, 0, 0, 1, 0, 0, lt, 0);
                end
            end
            if (!ended) begin
                push(0, 0, 0, 0, 1, 0, 0, lt, 0);
                if (lt && !first && !prev) begin
                    m_edge = m_tap;
                    n = (int'(m_tap) < BACKOFF) ? int'(m_tap) : BACKOFF;
                    for (int j = 0; j < n; j++) begin
                        push(0, 1, 0, 0, 1, 0, 0, lt, 0);
                        m_tap = m_tap - 4'd1;
                        repeat (SETTLE) push(0, 0, 0, 0, 1, 0, 0, lt, 0);
                    end
                    m_fin = m_tap;
                    repeat (3) push(0, 0, 0, 0, 0, 1, 0, lt, 0);
                    ended = 1'b1;
                end else if (int'(m_tap) == MAXT - 1) begin
                    repeat (3) push(0, 0, 0, 0, 0, 0, 1, lt, 0);
                    ended = 1'b1;
                end else begin
                    prev  = lt;
                    first = 1'b0;
                    push(0, 1, 1, 0, 1, 0, 0, lt, 0);
                    m_tap = m_tap + 4'd1;
                end
            end
        end
    endtask

    task automatic run(input int abort_idx, input bit spam,
                       output int n_inc, output int n_dec, output int n_load);
        n_inc = 0; n_dec = 0; n_load = 0;
        START = 1'b1;
        @(posedge clk); #1;
        START = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            LATE  = late_q[k];
            EARLY = ~late_q[k];
            OOR   = oor_q[k];
            START = spam && exp_q[k][14] && (k % 5 == 2);
            if (k == abort_idx) begin
                RESET = 1'b1;
                START = 1'b0;
                @(posedge clk); #1;
                RESET = 1'b0;
                OOR   = 1'b0;
                return;
            end
            @(negedge clk);
            check($sformatf("cycle%0d", k), actual(), exp_q[k]);
            check("pulse_exclusive", $countones({LOAD, MOVE, CLR}) > 1, 0);
            if (LOAD) n_load++;
            if (MOVE && DIR) n_inc++;
            if (MOVE && !DIR) n_dec++;
            @(posedge clk); #1;
        end
        START = 1'b0;
        OOR   = 1'b0;
    endtask

    initial begin
        int ni, nd, nl, abort_idx;
        RESET = 1'b1; START = 1'b0; LATE = 1'b0; EARLY = 1'b0; OOR = 1'b0;
        repeat (3) @(posedge clk);
        #1 RESET = 1'b0;
        @(negedge clk);
        check("reset_state", actual(), 0);

        build(16'hFFC0, -1);
        run(-1, 1'b0, ni, nd, nl);
        check("t1_inc_moves", ni, 6);
        check("t1_dec_moves", nd, 2);
        check("t1_loads", nl, 1);
        check("t1_edge_tap", EDGE_TAP, 6);
        check("t1_final_tap", FINAL_TAP, 4);
        check("t1_done", DONE, 1);

        build(16'hFFFF, -1);
        run(-1, 1'b0, ni, nd, nl);
        check("t2_inc_moves", ni, 15);
        check("t2_fail", FAIL, 1);
        check("t2_done", DONE, 0);

        build(16'hFFFE, -1);
        run(-1, 1'b0, ni, nd, nl);
        check("t3_edge_tap", EDGE_TAP, 1);
        check("t3_final_tap", FINAL_TAP, 0);
        check("t3_dec_moves", nd, 1);
        check("t3_done", DONE, 1);

        build(16'h0000, 3);
        run(-1, 1'b0, ni, nd, nl);
        check("t4_fail", FAIL, 1);
        check("t4_cur_tap", CUR_TAP, 3);
        check("t4_inc_moves", ni, 3);

        build(16'hFFC0, -1);
        abort_idx = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (abort_idx < 0 && exp_q[k][17] && !exp_q[k][16]) abort_idx = k;
        end
        run(abort_idx, 1'b0, ni, nd, nl);
        @(negedge clk);
        check("t5_after_reset", actual(), 0);
        run(-1, 1'b0, ni, nd, nl);
        check("t5_rerun_edge", EDGE_TAP, 6);
        check("t5_rerun_final", FINAL_TAP, 4);
        check("t5_rerun_loads", nl, 1);

        run(-1, 1'b1, ni, nd, nl);
        check("t6_inc_moves", ni, 6);
        check("t6_dec_moves", nd, 2);
        check("t6_loads", nl, 1);
        check("t6_edge_tap", EDGE_TAP, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dqsw_delay_trainer.md
Name: dqsw_delay_trainer

Overview:
Training sequencer for one DDR4 DQSW (DQSW270) training IOD lane. It drives the IOD's dynamic delay-line controls (LOAD/MOVE/DIRECTION) and eye-monitor flag clear. It steps the delay tap by tap, samples the EARLY/LATE flags and finds the first tap where LATE appears. It then backs off a programmable number of taps and reports the result. One instance sits beside each lane's DQSW training IOD and runs in the FAB_CLK domain.

Parameters:
MAX_TAPS, 128, number of usable delay taps; search fails when tap MAX_TAPS-1 is reached with no edge
TAP_W, 7, width of tap counters (clog2(MAX_TAPS))
SETTLE_CYCLES, 4, wait cycles after every LOAD/MOVE before clearing flags (>=1)
SAMPLE_CYCLES, 8, cycles the eye monitor accumulates after a clear before sampling (>=1)
BACKOFF_TAPS, 4, taps moved back (DIRECTION=0) after the edge is found

Ports:
FAB_CLK  in  1  single clock, all logic rising-edge
RESET  in  1  synchronous, active-high
START  in  1  one-cycle request; honoured only in IDLE, DONE or FAIL
BUSY  out  1  high in every state except IDLE/DONE/FAIL
DONE  out  1  level; high in DONE until next START or RESET
FAIL  out  1  level; high in FAIL until next START or RESET
FINAL_TAP  out  TAP_W  tap position after backoff; valid when DONE
EDGE_TAP  out  TAP_W  tap at which the edge was detected; valid when DONE
CUR_TAP  out  TAP_W  live tap position tracked by the block
DELAY_LINE_LOAD  out  1  one-cycle pulse; reloads IOD delay to its static value (tap 0)
DELAY_LINE_MOVE  out  1  one-cycle pulse, one tap per pulse
DELAY_LINE_DIRECTION  out  1  1=increment, 0=decrement; valid in the MOVE cycle
EYE_MONITOR_CLEAR_FLAGS  out  1  one-cycle pulse
EYE_MONITOR_EARLY  in  1  IOD early flag (sticky until cleared)
EYE_MONITOR_LATE  in  1  IOD late flag (sticky until cleared)
DELAY_LINE_OUT_OF_RANGE  in  1  IOD delay-line limit indication

Behaviour:
- Reset values: all outputs 0, including the tap fields and DIRECTION. State = IDLE. Internal prev_late = 0, first = 1.
- States: IDLE, LOAD, SETTLE, CLEAR, SAMPLE, EVAL, STEP, BACKOFF, DONE, FAIL.
- IDLE/DONE/FAIL + START -> LOAD. DONE, FAIL and the tap outputs clear in the same edge. CUR_TAP is set to 0 and first is set to 1.
- LOAD: assert LOAD for 1 cycle -> SETTLE.
- SETTLE: counter runs SETTLE_CYCLES cycles -> CLEAR. The counter is reloaded on each entry.
- CLEAR: assert CLEAR_FLAGS for 1 cycle -> SAMPLE.
- SAMPLE: wait SAMPLE_CYCLES cycles -> EVAL.
- EVAL: registers EARLY/LATE in a single cycle, then takes the first matching rule below.
  - LATE=1 and first=0 and prev_late=0: edge found. EDGE_TAP := CUR_TAP. Backoff count = min(BACKOFF_TAPS, CUR_TAP). Go to BACKOFF, or to DONE if that count is 0.
  - CUR_TAP = MAX_TAPS-1: go to FAIL.
  - Otherwise: prev_late := LATE, first := 0, go to STEP.
- LATE=1 on the first sample never counts as an edge. The search continues until LATE has been seen at 0 and then at 1.
- EARLY is sampled but not used in the edge decision.
- STEP: MOVE=1, DIRECTION=1 for 1 cycle, CUR_TAP += 1 -> SETTLE.
- BACKOFF: each move is MOVE=1, DIRECTION=0 for 1 cycle, CUR_TAP -= 1, then SETTLE_CYCLES idle cycles. Repeat until the count is exhausted, then FINAL_TAP := CUR_TAP -> DONE.
  - Backoff never drops below tap 0; the clamp is applied at EVAL.
- DELAY_LINE_OUT_OF_RANGE = 1 in any active state (LOAD through BACKOFF) goes to FAIL on the next edge. FAIL has priority over every other transition in that cycle.
- START while BUSY is ignored. There is no abort port; RESET is the only abort.
- RESET mid-sequence: IDLE next cycle, all pulse outputs 0. No further moves are issued. The IOD delay is left where it was; the next START reloads it.
- Per-tap cost: 1 (MOVE) + SETTLE_CYCLES + 1 (CLEAR) + SAMPLE_CYCLES + 1 (EVAL).
- Initial latency from START to the first EVAL: 1 + 1 (LOAD) + SETTLE_CYCLES + 1 + SAMPLE_CYCLES.
- At most one of LOAD, MOVE, CLEAR_FLAGS is high in any cycle.

Test Plan:
- Params MAX_TAPS=16, SETTLE=2, SAMPLE=4, BACKOFF=2. Model LATE=1 when tap>=6 -> EDGE_TAP=6, FINAL_TAP=4, DONE=1. Exactly 6 increment MOVE pulses and 2 decrement pulses; LOAD pulsed once.
- LATE=1 at every tap -> no edge. FAIL after the EVAL at tap 15 with exactly 15 increment MOVEs; DONE=0.
- Model LATE=0 at tap 0, 1 from tap 1 -> EDGE_TAP=1, backoff clamped to 1 move, FINAL_TAP=0, DONE.
- OUT_OF_RANGE pulsed for 1 cycle during SAMPLE at tap 3 -> FAIL next cycle, CUR_TAP=3, no further MOVE/CLEAR pulses.
- RESET asserted in BACKOFF -> next cycle all outputs 0 and IDLE. A new START yields a fresh LOAD and a correct result (EDGE_TAP=6 with the first model).
- START pulsed repeatedly while BUSY -> ignored: a single run with the same pulse counts as the first scenario. Check that LOAD/MOVE/CLEAR_FLAGS are never high together.
